// File: rtl/regfile_dump_reader.sv
// Walks register indices FIRST_REG..LAST_REG over the core's spare async read port
// and streams each captured word on a valid/ready channel tagged with its index.
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_IDLE | waiting for start; outputs quiet
// S_REQ  | requesting the read port, rd_addr = idx, capture on port_gnt
// S_SEND | captured word presented on out_*, waiting for out_ready
// S_DONE | one-cycle done pulse after the last word was accepted
module regfile_dump_reader #(
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 32,
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 31
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              port_req,
  input  logic              port_gnt,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_index,
  output logic              out_last
);

  if (FIRST_REG < 0 || FIRST_REG > LAST_REG || LAST_REG > (2**ADDR_W) - 1) begin : g_param_check
    $error("regfile_dump_reader: need 0 <= FIRST_REG <= LAST_REG <= 2**ADDR_W-1");
  end

  localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(FIRST_REG);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(LAST_REG);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_SEND = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] idx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // abort overrides every other transition, including a coincident start
  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (start) state_nxt = S_REQ;
        S_REQ:  if (port_gnt) state_nxt = S_SEND;
        S_SEND: if (out_ready) state_nxt = out_last ? S_DONE : S_REQ;
        S_DONE: state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy      = (state != S_IDLE);
    done      = (state == S_DONE);
    port_req  = (state == S_REQ);
    out_valid = (state == S_SEND);
    rd_addr   = (state == S_REQ) ? idx : '0;
  end

  // the last word ends the walk, so idx never needs to step past LAST_IDX
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx       <= '0;
      out_data  <= '0;
      out_index <= '0;
      out_last  <= 1'b0;
    end else begin
      if (state == S_IDLE && state_nxt == S_REQ) begin
        idx <= FIRST_IDX;
      end else if (state == S_SEND && state_nxt == S_REQ) begin
        idx <= idx + 1'b1;
      end
      if (state == S_REQ && state_nxt == S_SEND) begin
        out_data  <= rd_data;
        out_index <= idx;
        out_last  <= (idx == LAST_IDX);
      end
    end
  end

endmodule
